uart_tx: RTL and testbench

Byte-serial UART transmitter, 8N1, LSB first, with a runtime-programmable bit period. It is the transmit-side counterpart of `uart_rx` and uses the same `speed`/`set_speed` programming convention, so one divisor value configures both directions. It has a one-entry holding buffer, so the CPU can queue the next byte while the current frame shifts out. Consecutive frames then go out with no idle gap.

---
 rtl/uart_tx.sv | 121 ++++++++++++
 tb/tb_uart_tx.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, with a runtime-programmable bit period and a
// one-entry holding buffer so that consecutive frames go out back-to-back.
module uart_tx #(
    parameter logic [12:0] DEFAULT_SPEED = 13'h1869
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  data_to_send,
    input  logic        send,
    output logic        ready,
    input  logic [12:0] speed,
    input  logic        set_speed,
    output logic        tx,
    output logic        busy,
    output logic        tx_done
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_reg, state_next;
    logic [12:0] div_reg, div_next;
    logic [7:0]  buf_data_reg, buf_data_next;
    logic        buf_valid_reg, buf_valid_next;
    logic [7:0]  shreg_reg, shreg_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [12:0] cnt_reg, cnt_next;
    logic [12:0] last_cnt;
    logic        bit_end;

    // A divisor of zero behaves as one clock per bit.
    assign last_cnt = (div_reg == 13'd0) ? 13'd0 : div_reg - 13'd1;
    assign bit_end  = (cnt_reg == last_cnt);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            div_reg       <= DEFAULT_SPEED;
            buf_data_reg  <= 8'h00;
            buf_valid_reg <= 1'b0;
            shreg_reg     <= 8'h00;
            bit_idx_reg   <= 3'd0;
            cnt_reg       <= 13'd0;
        end else begin
            state_reg     <= state_next;
            div_reg       <= div_next;
            buf_data_reg  <= buf_data_next;
            buf_valid_reg <= buf_valid_next;
            shreg_reg     <= shreg_next;
            bit_idx_reg   <= bit_idx_next;
            cnt_reg       <= cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        div_next       = div_reg;
        buf_data_next  = buf_data_reg;
        buf_valid_next = buf_valid_reg;
        shreg_next     = shreg_reg;
        bit_idx_next   = bit_idx_reg;
        cnt_next       = (state_reg == IDLE || bit_end) ? 13'd0 : cnt_reg + 13'd1;
        ready          = !buf_valid_reg;
        busy           = (state_reg != IDLE);
        tx             = 1'b1;
        tx_done        = 1'b0;

        // Accept and unload are mutually exclusive: accept needs an empty buffer.
        if (send && !buf_valid_reg) begin
            buf_data_next  = data_to_send;
            buf_valid_next = 1'b1;
        end

        case (state_reg)
            IDLE: begin
                if (set_speed) begin
                    div_next = speed;
                end
                if (buf_valid_reg) begin
                    shreg_next     = buf_data_reg;
                    buf_valid_next = 1'b0;
                    state_next     = START;
                end
            end
            START: begin
                tx = 1'b0;
                if (bit_end) begin
                    bit_idx_next = 3'd0;
                    state_next   = DATA;
                end
            end
            DATA: begin
                tx = shreg_reg[bit_idx_reg];
                if (bit_end) begin
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            STOP: begin
                tx = 1'b1;
                if (bit_end) begin
                    tx_done = 1'b1;
                    // Chain straight into the next start bit when a byte is queued.
                    if (buf_valid_reg) begin
                        shreg_next     = buf_data_reg;
                        buf_valid_next = 1'b0;
                        state_next     = START;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: table-driven frames, hand-written corner sequences and
// randomized bursts checked against a bit-level frame model.
module tb_uart_tx;

    logic        clk;
    logic        reset;
    logic [7:0]  data_to_send;
    logic        send;
    logic        ready;
    logic [12:0] speed;
    logic        set_speed;
    logic        tx;
    logic        busy;
    logic        tx_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [12:0] spd;
        logic [7:0]  data;
        int          period;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] rb[3];

    uart_tx dut (
        .clk          (clk),
        .reset        (reset),
        .data_to_send (data_to_send),
        .send         (send),
        .ready        (ready),
        .speed        (speed),
        .set_speed    (set_speed),
        .tx           (tx),
        .busy         (busy),
        .tx_done      (tx_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #950000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_spd(input logic [12:0] v);
        speed     = v;
        set_speed = 1'b1;
        @(negedge clk);
        set_speed = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge just after the accepting edge.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        while (ready !== 1'b1 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) chk("send_ready_timeout", {31'd0, ready}, 32'd1);
        data_to_send = b;
        send         = 1'b1;
        @(negedge clk);
        send = 1'b0;
    endtask

    // Waits up to max_wait cycles for the start bit, then checks every cycle of a
    // 10*p frame against the expected line sequence {start, b[0..7], stop}.
    task automatic check_frame(input string name, input logic [7:0] b, input int p, input int max_wait);
        int         t;
        int         n;
        int         bad_tx;
        int         bad_done;
        int         bad_busy;
        logic [9:0] bits;
        logic [7:0] got;
        bits = {1'b1, b, 1'b0};
        n    = 10 * p;
        @(negedge clk);
        t = 0;
        while (tx !== 1'b0 && t < max_wait) begin
            @(negedge clk);
            t++;
        end
        if (tx !== 1'b0) begin
            chk({name, " start_bit"}, {31'd0, tx}, 32'd0);
            return;
        end
        bad_tx   = 0;
        bad_done = 0;
        bad_busy = 0;
        got      = 8'h00;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            if (tx !== bits[i / p]) bad_tx++;
            if (tx_done !== (i == n - 1)) bad_done++;
            if (busy !== 1'b1) bad_busy++;
            if (i >= p && i < 9 * p && (i % p) == p / 2) got[i / p - 1] = tx;
        end
        chk({name, " byte"}, {24'd0, got}, {24'd0, b});
        chk({name, " tx_wave_errs"}, bad_tx, 0);
        chk({name, " tx_done_errs"}, bad_done, 0);
        chk({name, " busy_errs"}, bad_busy, 0);
        $display("frame %s: byte %02h period %0d", name, got, p);
    endtask

    task automatic check_idle(input string name, input int cycles);
        int bad;
        bad = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) bad++;
        end
        chk({name, " idle_errs"}, bad, 0);
    endtask

    initial begin
        int t;
        int n;
        int p;
        int nb;
        logic [12:0] rs;

        vecs[0] = '{13'd4, 8'h55, 4};
        vecs[1] = '{13'd1, 8'hA5, 1};
        vecs[2] = '{13'd0, 8'h3C, 1};
        vecs[3] = '{13'd2, 8'h81, 2};
        vecs[4] = '{13'd7, 8'h00, 7};
        vecs[5] = '{13'd3, 8'hFF, 3};

        reset        = 1'b1;
        send         = 1'b0;
        set_speed    = 1'b0;
        speed        = 13'd0;
        data_to_send = 8'h00;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst tx", {31'd0, tx}, 32'd1);
        chk("rst ready", {31'd0, ready}, 32'd1);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst tx_done", {31'd0, tx_done}, 32'd0);

        // Single frames at a range of divisors.
        for (int v = 0; v < 6; v++) begin
            set_spd(vecs[v].spd);
            send_byte(vecs[v].data);
            chk($sformatf("vec%0d ready_drop", v), {31'd0, ready}, 32'd0);
            chk($sformatf("vec%0d busy_pre", v), {31'd0, busy}, 32'd0);
            check_frame($sformatf("vec%0d", v), vecs[v].data, vecs[v].period, 0);
            @(negedge clk);
            chk($sformatf("vec%0d idle_tx", v), {31'd0, tx}, 32'd1);
            chk($sformatf("vec%0d idle_busy", v), {31'd0, busy}, 32'd0);
            chk($sformatf("vec%0d idle_ready", v), {31'd0, ready}, 32'd1);
        end

        // Back-to-back frames, plus a third send while the buffer is full.
        set_spd(13'd4);
        fork
            begin
                send_byte(8'hA3);
                send_byte(8'h0F);
                chk("full ready", {31'd0, ready}, 32'd0);
                data_to_send = 8'h77;
                send         = 1'b1;
                @(negedge clk);
                send = 1'b0;
            end
            begin
                check_frame("b2b_0", 8'hA3, 4, 20);
                check_frame("b2b_1", 8'h0F, 4, 0);
                check_idle("b2b_after", 60);
            end
        join

        // set_speed mid-frame is ignored.
        fork
            begin
                send_byte(8'h3C);
                repeat (8) @(negedge clk);
                speed     = 13'd2;
                set_speed = 1'b1;
                @(negedge clk);
                set_speed = 1'b0;
            end
            check_frame("midspd", 8'h3C, 4, 20);
        join
        fork
            send_byte(8'hC3);
            check_frame("midspd_next", 8'hC3, 4, 20);
        join
        // set_speed in IDLE on the same edge that unloads the buffer applies.
        fork
            begin
                data_to_send = 8'h5A;
                send         = 1'b1;
                @(negedge clk);
                send      = 1'b0;
                speed     = 13'd2;
                set_speed = 1'b1;
                @(negedge clk);
                set_speed = 1'b0;
            end
            check_frame("idlespd", 8'h5A, 2, 5);
        join
        @(negedge clk);

        // Randomized bursts of 1-3 bytes at random divisors.
        for (int r = 0; r < 8; r++) begin
            rs = 13'($urandom_range(0, 6));
            p  = (rs == 13'd0) ? 1 : int'(rs);
            nb = $urandom_range(1, 3);
            for (int k = 0; k < 3; k++) rb[k] = 8'($urandom);
            set_spd(rs);
            fork
                begin
                    for (int k = 0; k < nb; k++) send_byte(rb[k]);
                end
                begin
                    for (int k = 0; k < nb; k++)
                        check_frame($sformatf("rnd%0d_%0d", r, k), rb[k], p, (k == 0) ? 20 : 0);
                end
            join
            check_idle($sformatf("rnd%0d", r), 3);
        end

        // Fresh reset: default divisor gives a 62490-cycle frame.
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        fork
            send_byte(8'hFF);
            check_frame("default", 8'hFF, 6249, 20);
        join

        // Reset during data bit 3 aborts the frame.
        set_spd(13'd4);
        send_byte(8'h00);
        t = 0;
        while (tx !== 1'b0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("abort start", {31'd0, tx}, 32'd0);
        repeat (17) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort tx", {31'd0, tx}, 32'd1);
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort ready", {31'd0, ready}, 32'd1);
        chk("abort tx_done", {31'd0, tx_done}, 32'd0);
        check_idle("abort_after", 30);

        // Divisor restored to default: start bit lasts 6249 cycles.
        send_byte(8'hFF);
        t = 0;
        while (tx !== 1'b0 && t < 10) begin
            @(negedge clk);
            t++;
        end
        n = 0;
        while (tx === 1'b0 && n < 7000) begin
            @(negedge clk);
            n++;
        end
        chk("abort div_restored", n, 6249);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        set_spd(13'd3);
        fork
            send_byte(8'h96);
            check_frame("post_abort", 8'h96, 3, 20);
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
